// File: rtl/ext_interrupt_generator.sv
// ext_interrupt_generator: paced external interrupt line with request queue and acknowledge handshake.
// Define EXT_INT_ACK_TIMEOUT_EN to abandon an unacknowledged interrupt after P_TIMEOUT_CYCLES.
`timescale 1ns/1ps
module ext_interrupt_generator #(
  parameter int P_PULSE_CYCLES   = 20,
  parameter int P_HOLDOFF_CYCLES = 20,
  parameter int P_TIMEOUT_CYCLES = 1000
) (
  input  logic       i_clk_20mhz,
  input  logic       i_rst_20mhz,
  input  logic       i_int_req,
  input  logic       ei_int_ack,
  input  logic       i_clr_status,
  output logic       eo_interrupt,
  output logic       o_busy,
  output logic [3:0] o_pending,
  output logic       o_overflow,
  output logic       o_timeout
);
  localparam int M1   = P_PULSE_CYCLES > P_HOLDOFF_CYCLES ? P_PULSE_CYCLES : P_HOLDOFF_CYCLES;
  localparam int CMAX = M1 > P_TIMEOUT_CYCLES ? M1 : P_TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] C_PULSE = CW'(P_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(P_HOLDOFF_CYCLES - 1);
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ASSERT   = 2'b01,
    ST_WAIT_ACK = 2'b11,
    ST_HOLDOFF  = 2'b10
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pend_q, pend_d;
  logic          ack_m_q, ack_s_q;
  logic          ack_seen_q, ack_seen_d;
  logic          int_q, int_d;
  logic          ovf_q, ovf_d;
  logic          enq, deq, full, ovf_set, to_set;
`ifdef EXT_INT_ACK_TIMEOUT_EN
  localparam logic [CW-1:0] C_TO = CW'(P_TIMEOUT_CYCLES - 1);
  logic          to_q;
  assign to_set    = state_q == ST_WAIT_ACK && !ack_s_q && cnt_q == C_TO;
  assign o_timeout = to_q;
`else
  assign to_set    = 1'b0;
  assign o_timeout = 1'b0;
`endif
  // A request in IDLE behind a non-empty queue is queued so the oldest goes first
  assign enq     = i_int_req && (state_q != ST_IDLE || pend_q != 4'd0);
  assign full    = pend_q == 4'hf;
  assign ovf_set = enq && !deq && full;
  always_comb begin
    state_d = state_q;
    deq     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = (i_int_req || pend_q != 4'd0) ? ST_ASSERT : ST_IDLE;
        deq     = pend_q != 4'd0;
      end
      ST_ASSERT:   state_d = cnt_q != C_PULSE ? ST_ASSERT : (ack_seen_q || ack_s_q) ? ST_HOLDOFF : ST_WAIT_ACK;
      ST_WAIT_ACK: state_d = (ack_s_q || to_set) ? ST_HOLDOFF : ST_WAIT_ACK;
      ST_HOLDOFF: if (cnt_q >= C_HOLD && !ack_s_q) begin
        state_d = pend_q != 4'd0 ? ST_ASSERT : ST_IDLE;
        deq     = pend_q != 4'd0;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign cnt_d      = state_d != state_q ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  assign ack_seen_d = state_d != state_q ? 1'b0 : ack_seen_q | (state_q == ST_ASSERT && ack_s_q);
  assign int_d      = state_d == ST_ASSERT || state_d == ST_WAIT_ACK;
  assign pend_d     = (enq && !deq) ? (full ? pend_q : pend_q + 4'd1) : (!enq && deq) ? pend_q - 4'd1 : pend_q;
  assign ovf_d      = ovf_set || (ovf_q && !i_clr_status);
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= 4'd0;
      ack_m_q    <= 1'b0;
      ack_s_q    <= 1'b0;
      ack_seen_q <= 1'b0;
      int_q      <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef EXT_INT_ACK_TIMEOUT_EN
      to_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      ack_m_q    <= ei_int_ack;
      ack_s_q    <= ack_m_q;
      ack_seen_q <= ack_seen_d;
      int_q      <= int_d;
      ovf_q      <= ovf_d;
`ifdef EXT_INT_ACK_TIMEOUT_EN
      to_q       <= to_set || (to_q && !i_clr_status);
`endif
    end
  end
  assign eo_interrupt = int_q;
  assign o_busy       = state_q != ST_IDLE;
  assign o_pending    = pend_q;
  assign o_overflow   = ovf_q;
endmodule

// File: tb/tb_ext_interrupt_generator.sv
// tb_ext_interrupt_generator: directed stimulus; expected pulse widths queued, checked by a line monitor.
`timescale 1ns/1ps
module tb_ext_interrupt_generator;
  logic       clk = 1'b0, rst = 1'b1, req = 1'b0, ack_drv = 1'b0, ack_follow = 1'b0, clr = 1'b0;
  logic       eo_int, busy, ovf, tmo, ack;
  logic [3:0] pend;
  int         errors = 0, checks = 0;
  int         exp_q[$];
  assign ack = ack_follow ? eo_int : ack_drv;
  always #25 clk = ~clk;
  ext_interrupt_generator dut (
    .i_clk_20mhz (clk),
    .i_rst_20mhz (rst),
    .i_int_req   (req),
    .ei_int_ack  (ack),
    .i_clr_status(clr),
    .eo_interrupt(eo_int),
    .o_busy      (busy),
    .o_pending   (pend),
    .o_overflow  (ovf),
    .o_timeout   (tmo)
  );
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask
  // Monitor: every falling edge of the line retires one expected pulse width
  initial begin
    int   hi = 0, lo = 0;
    logic have_prev = 1'b0, prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (eo_int) begin
        if (!prev && have_prev) check("holdoff_gap_ge_20", int'(lo >= 20), 1);
        hi++;
      end else begin
        if (prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: width %0d, none expected", hi);
          end else check("pulse_width", hi, exp_q.pop_front());
          hi = 0;
          lo = 0;
          have_prev = 1'b1;
        end
        lo++;
      end
      if (rst) have_prev = 1'b0;
      prev = eo_int;
    end
  end
  initial begin
    #(60000 * 50);
    $display("FAIL watchdog: simulation exceeded cycle limit");
    $fatal(1);
  end
  initial begin
    tick(3);
    check("rst_interrupt", eo_int, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", pend, 0);
    check("rst_overflow", ovf, 0);
    check("rst_timeout", tmo, 0);
    rst = 1'b0;
    tick(2);
    // single request, short ack pulse during the assert window
    exp_q.push_back(20);
    req = 1'b1;
    tick();
    req = 1'b0;
    check("latency_one_clock", eo_int, 1);
    check("busy_while_active", busy, 1);
    tick(4);
    ack_drv = 1'b1;
    tick(4);
    ack_drv = 1'b0;
    wait_idle("single_idle", 200);
    check("single_pending", pend, 0);
    // three back-to-back requests, IC acks while the line is high
    ack_follow = 1'b1;
    repeat (3) exp_q.push_back(20);
    req = 1'b1;
    tick(3);
    req = 1'b0;
    check("pending_two", pend, 2);
    wait_idle("burst3_idle", 400);
    check("burst3_pending", pend, 0);
    // late ack: line stays high in WAIT_ACK, holdoff stalls while ack is still high
    ack_follow = 1'b0;
    exp_q.push_back(62);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick(59);
    ack_drv = 1'b1;
    tick(40);
    check("holdoff_stall_busy", busy, 1);
    check("holdoff_stall_line", eo_int, 0);
    ack_drv = 1'b0;
    wait_idle("late_ack_idle", 50);
    // queue saturation, overflow and clear priority
    ack_follow = 1'b1;
    repeat (16) exp_q.push_back(20);
    req = 1'b1;
    tick(21);
    req = 1'b0;
    check("pending_saturated", pend, 15);
    check("overflow_set", ovf, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("overflow_cleared", ovf, 0);
    check("pending_after_clear", pend, 15);
    req = 1'b1;
    clr = 1'b1;
    tick();
    req = 1'b0;
    clr = 1'b0;
    check("set_wins_clear", ovf, 1);
    check("pending_still_15", pend, 15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("overflow_cleared_again", ovf, 0);
    wait_idle("drain_idle", 1500);
    check("drain_pending", pend, 0);
    // reset ten clocks into ASSERT with three queued
    exp_q.push_back(10);
    req = 1'b1;
    tick(4);
    req = 1'b0;
    tick(6);
    check("pending_three", pend, 3);
    rst = 1'b1;
    tick();
    check("midrst_line", eo_int, 0);
    check("midrst_pending", pend, 0);
    check("midrst_busy", busy, 0);
    rst = 1'b0;
    tick(60);
    check("no_pulse_after_reset", eo_int, 0);
    check("idle_after_reset", busy, 0);
`ifdef EXT_INT_ACK_TIMEOUT_EN
    ack_follow = 1'b0;
    exp_q.push_back(1020);
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_idle("timeout_idle", 1200);
    check("timeout_set", tmo, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("timeout_cleared", tmo, 0);
`else
    check("timeout_tied_low", tmo, 0);
`endif
    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
